// File: rtl/pc_sched.sv
// Next-PC scheduler and pipeline-flow controller.
// Picks the next fetch address, drives stall/flush, owns EPC, trap state and mult/div busy.
//
// Ports:
//   i_clk, i_rst           clock, async active-high reset
//   i_pc                   current fetch word address
//   i_id_jump/_target      jump decoded in ID
//   i_ex_branch_taken/_target, i_ex_pc   branch resolution and EX address
//   i_load_use_hazard      ID needs a load still in EX
//   i_md_start, i_md_use   mult/div issue in EX, HI/LO read in ID
//   i_exc, i_irq, i_eret   exception, interrupt (level), return from trap
//   o_next_pc              next fetch address
//   o_pc_stall, o_if_id_stall, o_if_id_flush, o_id_ex_flush, o_ex_mem_flush
//   o_epc, o_in_trap, o_md_busy
module pc_sched #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter int unsigned MD_LAT     = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [29:0] i_pc,
  input  logic        i_id_jump,
  input  logic [29:0] i_id_jump_target,
  input  logic        i_ex_branch_taken,
  input  logic [29:0] i_ex_branch_target,
  input  logic [29:0] i_ex_pc,
  input  logic        i_load_use_hazard,
  input  logic        i_md_start,
  input  logic        i_md_use,
  input  logic        i_exc,
  input  logic        i_irq,
  input  logic        i_eret,
  output logic [29:0] o_next_pc,
  output logic        o_pc_stall,
  output logic        o_if_id_stall,
  output logic        o_if_id_flush,
  output logic        o_id_ex_flush,
  output logic        o_ex_mem_flush,
  output logic [29:0] o_epc,
  output logic        o_in_trap,
  output logic        o_md_busy
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_TRAP = 1'b1
  } state_t;

  localparam logic [7:0]  LP_MD_LAT = MD_LAT[7:0];
  localparam logic [29:0] LP_RST_PC = RESET_ADDR[31:2];
  localparam logic [29:0] LP_EXC_PC = EXC_VECTOR[31:2];

  state_t      r_state;
  state_t      w_state_nxt;
  logic [29:0] r_epc;
  logic [7:0]  r_md_cnt;

  logic w_in_run;
  logic w_trap_take;
  logic w_eret_take;
  logic w_md_busy;
  logic w_stall;

  assign w_in_run    = (r_state == S_RUN);
  // irq is masked in TRAP; exc redirects in either state
  assign w_trap_take = i_exc | (i_irq & w_in_run);
  assign w_eret_take = i_eret & ~w_in_run;
  assign w_md_busy   = |r_md_cnt;
  assign w_stall     = i_load_use_hazard | (i_md_use & w_md_busy);

  assign o_epc     = r_epc;
  assign o_in_trap = ~w_in_run;
  assign o_md_busy = w_md_busy;

  always_comb begin
    o_next_pc      = i_pc + 30'd1;
    o_pc_stall     = 1'b0;
    o_if_id_stall  = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_ex_mem_flush = 1'b0;
    if (i_rst) begin
      o_next_pc = LP_RST_PC;
    end else if (w_trap_take) begin
      o_next_pc      = LP_EXC_PC;
      o_if_id_flush  = 1'b1;
      o_id_ex_flush  = 1'b1;
      o_ex_mem_flush = 1'b1;
    end else if (w_eret_take) begin
      o_next_pc     = r_epc;
      o_if_id_flush = 1'b1;
    end else if (i_ex_branch_taken) begin
      // wrong-path instruction sits in ID, so a branch beats any stall
      o_next_pc     = i_ex_branch_target;
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end else if (w_stall) begin
      o_next_pc     = i_pc;
      o_pc_stall    = 1'b1;
      o_if_id_stall = 1'b1;
      o_id_ex_flush = 1'b1;
    end else if (i_id_jump) begin
      o_next_pc     = i_id_jump_target;
      o_if_id_flush = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RUN:  if (w_trap_take) w_state_nxt = S_TRAP;
      S_TRAP: if (w_eret_take && !i_exc) w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_RUN;
      r_epc    <= '0;
      r_md_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_trap_take && w_in_run) r_epc <= i_ex_pc;
      if (w_trap_take)     r_md_cnt <= '0;
      else if (i_md_start) r_md_cnt <= LP_MD_LAT;
      else if (w_md_busy)  r_md_cnt <= r_md_cnt - 8'd1;
    end
  end

endmodule

// File: doc/pc_sched.md
# pc_sched

Next-PC scheduler and pipeline-flow controller for the 5-stage pipeline. It sits in front of the PC register and its pipeline registers. Every cycle it picks the next fetch address from the sequential, jump, branch, exception/interrupt and return sources. It also generates the PC stall plus the IF/ID, ID/EX and EX/MEM stall and flush controls, and owns the EPC register, the trap state and the multiply/divide busy counter.

## Interface
- RESET_ADDR, 32'h0000_0000: fetch address driven while in reset.
- EXC_VECTOR, 32'h0000_0080: exception and interrupt handler entry.
- MD_LAT, 8: mult/div latency in cycles, range 1..255.

- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- pc  in  [31:2]  current fetch word address.
- id_jump  in  1  J/JAL/JR decoded in ID.
- id_jump_target  in  [31:2]  jump target.
- ex_branch_taken  in  1  branch resolved taken in EX.
- ex_branch_target  in  [31:2]  branch target.
- ex_pc  in  [31:2]  address of the instruction in EX.
- load_use_hazard  in  1  ID consumes a load result that is still in EX.
- md_start  in  1  EX issues a mult/div this cycle.
- md_use  in  1  instruction in ID reads HI/LO.
- exc  in  1  synchronous exception raised by the EX instruction.
- irq  in  1  external interrupt request, level.
- eret  in  1  ERET decoded in ID.
- next_pc  out  [31:2]  next fetch address, loaded by the PC.
- pc_stall  out  1  hold the PC.
- if_id_stall  out  1  hold IF/ID.
- if_id_flush  out  1  clear IF/ID.
- id_ex_flush  out  1  insert a bubble into ID/EX.
- ex_mem_flush  out  1  kill the EX instruction.
- epc  out  [31:2]  saved return address.
- in_trap  out  1  high while in state TRAP.
- md_busy  out  1  mult/div counter nonzero.

## Operation
- States: RUN and TRAP.
  - RUN→TRAP on an accepted exc or irq.
  - TRAP→RUN on eret.
  - No other transitions.
- Priority per cycle, highest first; each event is described by what it drives.
  1. exc (any state), or irq (RUN only):
     - next_pc=EXC_VECTOR[31:2].
     - if_id_flush, id_ex_flush and ex_mem_flush all 1.
     - epc←ex_pc, only when leaving RUN.
     - An exc in TRAP redirects but leaves epc unchanged.
  2. eret in TRAP:
     - next_pc=epc and if_id_flush=1.
     - eret in RUN is ignored and falls through to the lower priorities.
  3. ex_branch_taken:
     - next_pc=ex_branch_target.
     - if_id_flush=1 and id_ex_flush=1.
     - Overrides any stall, because ID holds a wrong-path instruction.
  4. Stall, when load_use_hazard or (md_use and md_busy) is active:
     - pc_stall=1, if_id_stall=1, id_ex_flush=1.
     - next_pc=pc.
  5. id_jump:
     - next_pc=id_jump_target and if_id_flush=1.
  6. Otherwise: next_pc=pc+1 (30-bit add, wraps 3FFF_FFFF→0).
- Any output not named for the winning event is 0.
- The mult/div counter is 8 bits:
  - md_start loads MD_LAT, including while busy (restart).
  - Otherwise it decrements while nonzero.
  - md_busy is high while the counter is nonzero.
- An exception or interrupt redirect clears the counter to 0.
- Irq is masked while in_trap=1; a held irq is taken in the first RUN cycle after eret.

## Timing
- next_pc and all stall/flush outputs are combinational from the inputs, the state, epc and the counter; no added latency.
- A redirect takes effect at the next clk edge (the PC loads next_pc). The first target fetch is 1 cycle after the event.
- The state, epc and counter update on posedge clk.
- md_start at edge N gives md_busy=1 for cycles N+1 .. N+MD_LAT and 0 at N+MD_LAT+1.
- Reset, asynchronous and taking effect immediately:
  - state=RUN, epc=0, counter=0, in_trap=0, md_busy=0.
  - While rst=1, next_pc=RESET_ADDR[31:2] and all stall/flush outputs are 0.
- exc and eret in the same cycle: exc wins.
- irq and a taken branch together: irq wins and epc=ex_pc, so the branch is re-executed after eret.

## Test plan
- Reset mid-run: assert rst with pc=0x40 and a pending branch. Required: next_pc=0 immediately, all flushes 0, in_trap=0, epc=0.
- Sequential and wrap: pc=0x3FFF_FFFF with no events gives next_pc=0. Then id_jump with target 0x100 gives next_pc=0x100 and if_id_flush=1.
- Load-use stall with a simultaneous branch:
  - load_use alone: pc_stall=1, if_id_stall=1, id_ex_flush=1, next_pc=pc.
  - Adding ex_branch_taken with target 0x200: pc_stall=0, next_pc=0x200, both IF/ID and ID/EX flushes 1.
- Mult/div timing with MD_LAT=8:
  - md_start at cycle 0, then md_use held: stall in cycles 1..8, released in cycle 9.
  - A second md_start at cycle 4 extends the stall through cycle 12.
- Trap sequence:
  - exc with ex_pc=0x30: next_pc=0x20, all three flushes 1, epc=0x30 next cycle, in_trap=1.
  - irq while in_trap is ignored.
  - eret gives next_pc=0x30 and returns to RUN; a held irq is then taken the following cycle.
